// File: rtl/apb_uart_rx_pkg.sv
// apb_uart_rx_pkg: register offsets, status bit positions and receiver states
package apb_uart_rx_pkg;
  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT = 2'd2;
  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_FULL = 1;
  localparam int ST_OVERRUN = 2;
  localparam int ST_FRAME_ERR = 3;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_e;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte FIFO, extra pointer MSB distinguishes full from empty
module uart_rx_fifo #(
  parameter int ADDR_EXP = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                push,
  input  logic                pop,
  input  logic [7:0]          din,
  output logic [7:0]          dout,
  output logic                full,
  output logic                empty,
  output logic [ADDR_EXP:0]   count
);
  logic [7:0] mem [2**ADDR_EXP];
  logic [ADDR_EXP:0] wptr, rptr;
  logic do_push, do_pop;
  assign empty = wptr == rptr;
  assign full = (wptr[ADDR_EXP] != rptr[ADDR_EXP]) && (wptr[ADDR_EXP-1:0] == rptr[ADDR_EXP-1:0]);
  assign count = wptr - rptr;
  assign dout = mem[rptr[ADDR_EXP-1:0]];
  assign do_pop = pop & ~empty;
  // a full FIFO still accepts a push when the head leaves on the same edge
  assign do_push = push & (~full | do_pop);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= do_push ? wptr + 1'b1 : wptr;
      rptr <= do_pop ? rptr + 1'b1 : rptr;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[ADDR_EXP-1:0]] <= din;
  end
endmodule

// File: rtl/apb_uart_rx.sv
// apb_uart_rx: 8N1 UART receiver with byte FIFO and APB data/status/count registers
module apb_uart_rx
  import apb_uart_rx_pkg::*;
#(
  parameter int BUS_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CLKS_PER_BIT = 434,
  parameter int ADDR_EXP = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  S_PADDR,
  input  logic                  S_PWRITE,
  input  logic                  S_PSELx,
  input  logic                  S_PENABLE,
  input  logic [DATA_WIDTH-1:0] S_PWDATA,
  output logic [DATA_WIDTH-1:0] S_PRDATA,
  output logic                  S_PREADY,
  input  logic                  rx_wire,
  output logic                  rx_irq
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic sync1, sync2;
  rx_state_e state, state_n;
  logic [CW-1:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shreg, head;
  logic cnt_clr, shift_en, push_req, frame_bad;
  logic overrun, frame_err, full, empty, pop, wr_status, access;
  logic [ADDR_EXP:0] count;
  logic [DATA_WIDTH-1:0] status;
  logic [1:0] addr;
  logic unused_bits;
  assign unused_bits = ^{S_PADDR[BUS_WIDTH-1:2], S_PWDATA[DATA_WIDTH-1:4], S_PWDATA[1:0]};
  assign addr = S_PADDR[1:0];
  assign access = S_PSELx & S_PENABLE;
  assign S_PREADY = access;
  assign pop = access & ~S_PWRITE & (addr == REG_DATA);
  assign wr_status = access & S_PWRITE & (addr == REG_STATUS);
  assign rx_irq = ~empty;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      state <= IDLE;
    end else begin
      sync1 <= rx_wire;
      sync2 <= sync1;
      state <= state_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    shift_en = 1'b0;
    push_req = 1'b0;
    frame_bad = 1'b0;
    case (state)
      IDLE: begin
        cnt_clr = ~sync2;
        state_n = sync2 ? IDLE : START;
      end
      START: if (cnt == HALF) begin
        cnt_clr = 1'b1;
        state_n = sync2 ? IDLE : DATA;
      end
      DATA: if (cnt == LAST) begin
        cnt_clr = 1'b1;
        shift_en = 1'b1;
        state_n = (bit_idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == LAST) begin
        cnt_clr = 1'b1;
        push_req = sync2;
        frame_bad = ~sync2;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end
  // sticky flags: a new event wins over a software clear on the same edge
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      bit_idx <= '0;
      shreg <= '0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + 1'b1;
      bit_idx <= (state != DATA) ? 3'd0 : shift_en ? bit_idx + 3'd1 : bit_idx;
      shreg <= shift_en ? {sync2, shreg[7:1]} : shreg;
      overrun <= (push_req & full & ~pop) | (overrun & ~(wr_status & S_PWDATA[ST_OVERRUN]));
      frame_err <= frame_bad | (frame_err & ~(wr_status & S_PWDATA[ST_FRAME_ERR]));
    end
  end
  uart_rx_fifo #(.ADDR_EXP(ADDR_EXP)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push_req),
    .pop(pop),
    .din(shreg),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  always_comb begin
    status = '0;
    status[ST_NOT_EMPTY] = ~empty;
    status[ST_FULL] = full;
    status[ST_OVERRUN] = overrun;
    status[ST_FRAME_ERR] = frame_err;
    S_PRDATA = !S_PSELx ? '0 :
               (addr == REG_DATA) ? DATA_WIDTH'(empty ? 8'h00 : head) :
               (addr == REG_STATUS) ? status :
               (addr == REG_COUNT) ? DATA_WIDTH'(count) : '0;
  end
endmodule

// File: tb/tb_apb_uart_rx.sv
// tb_apb_uart_rx: frame-table and corner-sequence bench with a byte scoreboard
module tb_apb_uart_rx;
  localparam int CPB = 8;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [15:0] S_PADDR = '0;
  logic S_PWRITE = 1'b0;
  logic S_PSELx = 1'b0;
  logic S_PENABLE = 1'b0;
  logic [15:0] S_PWDATA = '0;
  logic [15:0] S_PRDATA;
  logic S_PREADY;
  logic rx_wire = 1'b1;
  logic rx_irq;
  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  logic [15:0] rd;
  logic rdy;
  int cyc;

  typedef struct {
    logic [7:0] data;
    logic stop;
    logic [15:0] status;
    logic [15:0] count;
  } vec_t;
  vec_t vecs[4];

  apb_uart_rx #(.BUS_WIDTH(16), .DATA_WIDTH(16), .CLKS_PER_BIT(CPB), .ADDR_EXP(4)) dut (
    .clk(clk), .reset(reset), .S_PADDR(S_PADDR), .S_PWRITE(S_PWRITE), .S_PSELx(S_PSELx),
    .S_PENABLE(S_PENABLE), .S_PWDATA(S_PWDATA), .S_PRDATA(S_PRDATA), .S_PREADY(S_PREADY),
    .rx_wire(rx_wire), .rx_irq(rx_irq)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb_read(input logic [1:0] a, output logic [15:0] d, output logic r);
    S_PSELx = 1'b1; S_PWRITE = 1'b0; S_PADDR = {14'b0, a}; S_PENABLE = 1'b0;
    @(negedge clk); S_PENABLE = 1'b1;
    #1 d = S_PRDATA; r = S_PREADY;
    @(negedge clk); S_PSELx = 1'b0; S_PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [1:0] a, input logic [15:0] d);
    S_PSELx = 1'b1; S_PWRITE = 1'b1; S_PADDR = {14'b0, a}; S_PWDATA = d; S_PENABLE = 1'b0;
    @(negedge clk); S_PENABLE = 1'b1;
    @(negedge clk); S_PSELx = 1'b0; S_PENABLE = 1'b0; S_PWRITE = 1'b0;
  endtask

  task automatic read_chk(input string name, input logic [1:0] a, input logic [15:0] exp);
    logic [15:0] d;
    logic r;
    apb_read(a, d, r);
    chk(name, {16'h0, d}, {16'h0, exp});
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rx_wire = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_wire = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx_wire = stop;
    repeat (CPB) @(negedge clk);
    rx_wire = 1'b1;
  endtask

  task automatic send_model(input logic [7:0] b);
    send_frame(b, 1'b1);
    if (sb.size() < DEPTH) sb.push_back(b);
    repeat (10) @(negedge clk);
  endtask

  task automatic drain(input int n);
    logic [15:0] d;
    logic r;
    for (int i = 0; i < n; i++) begin
      apb_read(2'd0, d, r);
      chk("data_order", {16'h0, d}, {24'h0, (sb.size() > 0) ? sb.pop_front() : 8'h00});
    end
  endtask

  initial begin
    vecs[0] = '{data: 8'h5C, stop: 1'b1, status: 16'h0001, count: 16'd1};
    vecs[1] = '{data: 8'h3C, stop: 1'b0, status: 16'h0009, count: 16'd1};
    vecs[2] = '{data: 8'hFF, stop: 1'b1, status: 16'h0009, count: 16'd2};
    vecs[3] = '{data: 8'h00, stop: 1'b1, status: 16'h000B & 16'h0009, count: 16'd3};

    #2;
    chk("reset_prdata", {16'h0, S_PRDATA}, 32'h0);
    chk("reset_pready", {31'h0, S_PREADY}, 32'h0);
    chk("reset_irq", {31'h0, rx_irq}, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    read_chk("reset_count", 2'd2, 16'h0000);
    read_chk("reset_status", 2'd1, 16'h0000);
    read_chk("empty_data", 2'd0, 16'h0000);
    read_chk("empty_after_read_status", 2'd1, 16'h0000);
    read_chk("reserved", 2'd3, 16'h0000);

    cyc = 0;
    fork
      send_frame(8'hA5, 1'b1);
      while (!rx_irq && cyc < 200) begin
        @(negedge clk);
        cyc++;
      end
    join
    checks++;
    if (cyc < 78 || cyc > 80) begin
      errors++;
      $display("FAIL irq_latency: got %0d cycles, required 79 +/-1", cyc);
    end
    sb.push_back(8'hA5);
    repeat (4) @(negedge clk);
    read_chk("a5_status", 2'd1, 16'h0001);
    read_chk("a5_count", 2'd2, 16'h0001);
    apb_read(2'd0, rd, rdy);
    chk("a5_pready", {31'h0, rdy}, 32'h1);
    chk("a5_data", {16'h0, rd}, {24'h0, sb.pop_front()});
    read_chk("a5_status_after", 2'd1, 16'h0000);

    for (int i = 0; i < 4; i++) begin
      send_frame(vecs[i].data, vecs[i].stop);
      if (vecs[i].stop) sb.push_back(vecs[i].data);
      repeat (10) @(negedge clk);
      read_chk("vec_status", 2'd1, vecs[i].status);
      read_chk("vec_count", 2'd2, vecs[i].count);
    end
    drain(3);
    read_chk("vec_drained_status", 2'd1, 16'h0008);
    apb_write(2'd1, 16'h0008);
    read_chk("frame_err_cleared", 2'd1, 16'h0000);

    rx_wire = 1'b0;
    repeat (2) @(negedge clk);
    rx_wire = 1'b1;
    repeat (20) @(negedge clk);
    read_chk("glitch_count", 2'd2, 16'h0000);
    read_chk("glitch_status", 2'd1, 16'h0000);

    for (int i = 0; i < 17; i++) send_model(8'(i));
    read_chk("ovr_count", 2'd2, 16'd16);
    read_chk("ovr_status", 2'd1, 16'h0007);
    drain(16);
    read_chk("ovr_drained_status", 2'd1, 16'h0004);
    apb_write(2'd1, 16'h0004);
    read_chk("ovr_cleared", 2'd1, 16'h0000);

    for (int i = 0; i < 16; i++) send_model(8'h20 + 8'(i));
    read_chk("full_status", 2'd1, 16'h0003);
    fork
      send_frame(8'h30, 1'b1);
      begin
        repeat (77) @(negedge clk);
        apb_read(2'd0, rd, rdy);
      end
    join
    chk("simul_pop_data", {16'h0, rd}, {24'h0, sb.pop_front()});
    sb.push_back(8'h30);
    repeat (4) @(negedge clk);
    read_chk("simul_count", 2'd2, 16'd16);
    read_chk("simul_status", 2'd1, 16'h0003);
    drain(16);

    send_model(8'h11);
    send_model(8'h22);
    send_model(8'h33);
    read_chk("pre_reset_count", 2'd2, 16'd3);
    fork
      send_frame(8'hF3, 1'b1);
      begin
        repeat (44) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midrst_irq", {31'h0, rx_irq}, 32'h0);
        chk("midrst_pready", {31'h0, S_PREADY}, 32'h0);
        chk("midrst_prdata", {16'h0, S_PRDATA}, 32'h0);
        S_PSELx = 1'b1; S_PADDR = 16'd2;
        #1 chk("midrst_count", {16'h0, S_PRDATA}, 32'h0);
        S_PADDR = 16'd1;
        #1 chk("midrst_status", {16'h0, S_PRDATA}, 32'h0);
        S_PSELx = 1'b0; S_PADDR = 16'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
      end
    join
    sb.delete();
    repeat (10) @(negedge clk);
    read_chk("post_rst_count", 2'd2, 16'h0000);
    read_chk("post_rst_status", 2'd1, 16'h0000);
    send_model(8'h5A);
    read_chk("post_rst_5a_count", 2'd2, 16'd1);
    drain(1);
    read_chk("final_status", 2'd1, 16'h0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_uart_rx.md
# apb_uart_rx

APB slave UART receiver: the receive-side counterpart of the peripheral section's transmit-only UART, consuming the `uart_rx` pin and occupying a free slot on the peripheral interconnect. It deserialises 8N1 frames from an asynchronous serial line, buffers received bytes in a FIFO, and exposes data, status and fill level as APB registers. Software polls status or uses `rx_irq` to drain the FIFO.

## Interface
Parameters:
- BUS_WIDTH, 16, APB address width
- DATA_WIDTH, 16, APB data width; received byte in bits [7:0], upper bits zero
- CLKS_PER_BIT, 434, clk cycles per serial bit (50 MHz / 115200); minimum 4
- ADDR_EXP, 4, FIFO depth = 2^ADDR_EXP bytes

Ports:
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-high
- S_PADDR  in  BUS_WIDTH  APB address; register offset = S_PADDR[1:0]
- S_PWRITE  in  1  APB write
- S_PSELx  in  1  APB select
- S_PENABLE  in  1  APB access phase
- S_PWDATA  in  DATA_WIDTH  APB write data
- S_PRDATA  out  DATA_WIDTH  APB read data
- S_PREADY  out  1  APB ready
- rx_wire  in  1  serial input, idle high, asynchronous to clk
- rx_irq  out  1  high while FIFO non-empty

## Operation
- Register map (offset): 0 DATA (read pops FIFO head; write ignored); 1 STATUS {12'b0, frame_err, overrun, full, not_empty} (write with bit2/bit3 set clears corresponding sticky flag); 2 COUNT (entries, 0..2^ADDR_EXP); 3 reserved, reads 0.
- rx_wire passes through 2-flop synchroniser, both flops reset to 1.
- Bit counter 0..CLKS_PER_BIT-1; bit index 0..7.
- FSM: IDLE -> START when synced line = 0, counter cleared. START: at counter = CLKS_PER_BIT/2 - 1 sample; 0 -> DATA (counter cleared), 1 -> IDLE (glitch, nothing recorded). DATA: sample at counter = CLKS_PER_BIT-1, shift in LSB first; after bit 7 -> STOP. STOP: sample at counter = CLKS_PER_BIT-1; -> IDLE.
- Stop sample 1: push byte; if FIFO full and no pop that cycle, drop byte, set overrun. Stop sample 0: drop byte, set frame_err.
- Sticky flags set-dominant: set and software clear in same cycle -> flag stays set.
- Read DATA when empty: returns 0x0000, no pop, no flag.
- Push and pop same cycle: both occur, COUNT unchanged; applies also when full.

## Timing
- Reset values: S_PRDATA 0, S_PREADY 0, rx_irq 0, FSM IDLE, FIFO empty, COUNT 0, flags 0, shift register 0.
- Reset asserted mid-frame: frame discarded, FIFO flushed; after release, receiver waits in IDLE for next falling edge (line must be seen high-to-low anew only if still low: a low line immediately restarts START).
- S_PREADY = S_PSELx & S_PENABLE, combinational; zero wait states.
- S_PRDATA combinational from selected register while S_PSELx high, else 0; DATA reads show head before pop.
- Pop and sticky clear take effect on the clk edge ending the access phase.
- Push occurs on the edge of the stop sample; not_empty, COUNT, rx_irq update one cycle later (registered).
- Frame latency from rx_wire fall to rx_irq rise: 2 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT + 1 cycles (±1 for input phase).

## Structure
- Shared include: register offsets, STATUS bit positions, FSM state encodings (localparam-style defines alongside existing peripheral PSEL defines); a new peripheral PSEL index for UART RX.
- Sub-module uart_rx_fifo: synchronous FIFO, 8-bit wide, 2^ADDR_EXP deep, push/pop/full/empty/count, pointers wrap modulo depth with extra MSB for full detection.
- Top level holds synchroniser, FSM, flags, APB decode.

## Test plan
- CLKS_PER_BIT=8: send 0xA5 8N1 -> rx_irq rises within 2+4+72+1 ±1 cycles; STATUS=0x0001, COUNT=1; read DATA=0x00A5; next STATUS=0x0000.
- Send 17 bytes 0x00..0x10 with depth 16, no reads -> COUNT=16, STATUS=0x0007 (overrun,full,not_empty); reads return 0x00..0x0F in order; byte 0x10 lost.
- Frame with stop bit 0 (data 0x3C) -> COUNT stays 0, STATUS bit3 set; write STATUS 0x0008 -> STATUS=0x0000.
- Low glitch of 2 cycles on idle line -> FSM returns IDLE, COUNT 0, no flags.
- FIFO full, DATA read on the same edge as next push -> no overrun, COUNT stays 16, order preserved.
- Assert reset at bit 4 of a frame with 3 bytes queued -> all outputs at reset values; subsequent clean frame 0x5A received correctly, COUNT=1.
